// File: rtl/anc_adapt_sched.sv
// ============================================================================
// anc_adapt_sched : sequences the LMS weight-update unit over all FIR taps
// Rev 1.0
// ============================================================================
`default_nettype none

module anc_adapt_sched #(
  parameter int TAPS      = 16,
  parameter int AW        = 4,
  parameter int DW        = 11,
  parameter int ADAPT_LAT = 2
) (
  input  logic          Clk_100M,
  input  logic          Reset_n,
  input  logic          SampleStrobe,
  input  logic [DW-1:0] SigIn,
  input  logic [DW-1:0] ErrIn,
  input  logic          Freeze,
  input  logic          WeightClr,
  output logic          AdaptEN,
  output logic [DW-1:0] AdaptSigIn,
  output logic [DW-1:0] AdaptErr,
  output logic [DW-1:0] AdaptWzIn,
  input  logic [DW-1:0] AdaptWzOut,
  input  logic [AW-1:0] CoefAddr,
  output logic [DW-1:0] CoefData,
  output logic          Busy,
  output logic          Done,
  output logic          Overrun
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int            CW        = (ADAPT_LAT > 2) ? $clog2(ADAPT_LAT - 1) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'((ADAPT_LAT >= 2) ? (ADAPT_LAT - 2) : 0);
  localparam logic [AW-1:0] LAST_TAP  = AW'(TAPS - 1);
  localparam logic [AW:0]   TAPS_W    = (AW + 1)'(TAPS);

  logic [2:0]    state;
  logic [2:0]    next_state;
  logic [AW-1:0] k;
  logic [CW-1:0] wait_cnt;
  logic [DW-1:0] x [TAPS];
  logic [DW-1:0] w [TAPS];
  logic [DW-1:0] sig_hold;
  logic [DW-1:0] err_hold;
  logic          frz_hold;

  always_ff @(posedge Clk_100M or negedge Reset_n) begin
    if (!Reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (SampleStrobe) next_state = S_LOAD;
      S_LOAD:  next_state = frz_hold ? S_DONE : S_ISSUE;
      S_ISSUE: next_state = (ADAPT_LAT == 1) ? S_WRITE : S_WAIT;
      S_WAIT:  if (wait_cnt == WAIT_LAST) next_state = S_WRITE;
      S_WRITE: next_state = (k == LAST_TAP) ? S_DONE : S_ISSUE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    AdaptEN = 1'b0;
    Busy    = 1'b1;
    Done    = 1'b0;
    case (state)
      S_IDLE:  Busy    = 1'b0;
      S_ISSUE: AdaptEN = 1'b1;
      S_WAIT:  AdaptEN = 1'b1;
      S_DONE:  Done    = 1'b1;
      default: ;
    endcase
  end

  // Sample, error and freeze are captured at the strobe edge and applied in LOAD.
  always_ff @(posedge Clk_100M or negedge Reset_n) begin
    if (!Reset_n) begin
      k          <= '0;
      wait_cnt   <= '0;
      sig_hold   <= '0;
      err_hold   <= '0;
      frz_hold   <= 1'b0;
      AdaptSigIn <= '0;
      AdaptErr   <= '0;
      AdaptWzIn  <= '0;
      Overrun    <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        x[i] <= '0;
        w[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (SampleStrobe) begin
            sig_hold <= SigIn;
            err_hold <= ErrIn;
            frz_hold <= Freeze;
          end else if (WeightClr) begin
            Overrun <= 1'b0;
            for (int i = 0; i < TAPS; i++) w[i] <= '0;
          end
        end
        S_LOAD: begin
          for (int i = TAPS - 1; i > 0; i--) x[i] <= x[i-1];
          x[0]     <= sig_hold;
          AdaptErr <= err_hold;
          k        <= '0;
          if (!frz_hold) begin
            AdaptSigIn <= sig_hold;
            AdaptWzIn  <= w[0];
          end
        end
        S_ISSUE: wait_cnt <= '0;
        S_WAIT:  wait_cnt <= wait_cnt + CW'(1);
        S_WRITE: begin
          w[k] <= AdaptWzOut;
          if (k != LAST_TAP) begin
            k          <= k + AW'(1);
            AdaptSigIn <= x[k + AW'(1)];
            AdaptWzIn  <= w[k + AW'(1)];
          end
        end
        default: ;
      endcase
      if (state != S_IDLE && SampleStrobe) Overrun <= 1'b1;
    end
  end

  always_comb begin
    CoefData = '0;
    if ({1'b0, CoefAddr} < TAPS_W) CoefData = w[CoefAddr];
  end

endmodule

`default_nettype wire

// File: tb/tb_anc_adapt_sched.sv
// ============================================================================
// tb_anc_adapt_sched : randomized self-checking bench with a tap-level model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_anc_adapt_sched;

  localparam int TAPS      = 4;
  localparam int AW        = 4;
  localparam int DW        = 11;
  localparam int ADAPT_LAT = 2;

  logic          clk = 1'b0;
  logic          Reset_n;
  logic          SampleStrobe;
  logic [DW-1:0] SigIn, ErrIn;
  logic          Freeze, WeightClr;
  logic          AdaptEN;
  logic [DW-1:0] AdaptSigIn, AdaptErr, AdaptWzIn, AdaptWzOut;
  logic [AW-1:0] CoefAddr;
  logic [DW-1:0] CoefData;
  logic          Busy, Done, Overrun;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] mx [TAPS];
  logic [DW-1:0] mw [TAPS];
  logic [DW-1:0] me;
  logic          movr;
  bit            rich;
  logic [DW-1:0] p1, p2;

  always #5 clk = ~clk;

  anc_adapt_sched #(.TAPS(TAPS), .AW(AW), .DW(DW), .ADAPT_LAT(ADAPT_LAT)) dut (
    .Clk_100M(clk), .Reset_n(Reset_n), .SampleStrobe(SampleStrobe), .SigIn(SigIn),
    .ErrIn(ErrIn), .Freeze(Freeze), .WeightClr(WeightClr), .AdaptEN(AdaptEN),
    .AdaptSigIn(AdaptSigIn), .AdaptErr(AdaptErr), .AdaptWzIn(AdaptWzIn),
    .AdaptWzOut(AdaptWzOut), .CoefAddr(CoefAddr), .CoefData(CoefData),
    .Busy(Busy), .Done(Done), .Overrun(Overrun)
  );

  // Stand-in adapter: plain +1 per update, or an input-dependent step when rich.
  function automatic logic [DW-1:0] delta(input logic [DW-1:0] xs, input logic [DW-1:0] es);
    logic [DW-1:0] d;
    d = rich ? ((xs ^ es) + DW'(1)) : DW'(1);
    return d;
  endfunction

  always @(posedge clk) begin
    if (AdaptEN) p1 <= AdaptWzIn + delta(AdaptSigIn, AdaptErr);
    p2 <= p1;
  end
  assign AdaptWzOut = p2;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < TAPS; i++) begin
      mx[i] = '0;
      mw[i] = '0;
    end
    me   = '0;
    movr = 1'b0;
  endtask

  task automatic check_idle_outs(input string tag);
    check_val({tag, "_busy"}, Busy, 0);
    check_val({tag, "_done"}, Done, 0);
    check_val({tag, "_en"}, AdaptEN, 0);
    check_val({tag, "_ovr"}, Overrun, 0);
    check_val({tag, "_sig"}, AdaptSigIn, 0);
    check_val({tag, "_err"}, AdaptErr, 0);
    check_val({tag, "_wz"}, AdaptWzIn, 0);
    check_val({tag, "_coef"}, CoefData, 0);
  endtask

  task automatic sweep(input string tag);
    logic [DW-1:0] exp;
    for (int a = 0; a < 16; a++) begin
      CoefAddr = AW'(a);
      #1;
      exp = '0;
      if (a < TAPS) exp = mw[a];
      check_val(tag, CoefData, exp);
    end
  endtask

  // One strobe and the pass it triggers; ov_at injects a stray strobe, rst_at aborts via reset.
  task automatic run_pass(input logic [DW-1:0] s, input logic [DW-1:0] e, input logic f,
                          input int ov_at, input int rst_at);
    int   cyc, en_cnt, tap;
    logic prev_en, seen_done;
    @(posedge clk); #1;
    SampleStrobe = 1'b1; SigIn = s; ErrIn = e; Freeze = f;
    WeightClr = 1'($urandom_range(0, 1));
    for (int i = TAPS - 1; i > 0; i--) mx[i] = mx[i-1];
    mx[0] = s;
    me    = e;
    @(posedge clk); #1;
    SampleStrobe = 1'b0; SigIn = DW'($urandom); ErrIn = DW'($urandom);
    Freeze = 1'($urandom_range(0, 1));
    cyc = 1; en_cnt = 0; tap = 0; prev_en = 1'b0; seen_done = 1'b0;
    @(negedge clk);
    check_val("busy_after_strobe", Busy, 1);
    while (cyc < 100) begin
      if (cyc == rst_at) begin
        Reset_n = 1'b0; WeightClr = 1'b0; SampleStrobe = 1'b0;
        #1;
        model_reset();
        check_idle_outs("midpass_rst");
        @(negedge clk);
        Reset_n = 1'b1;
        sweep("midpass_rst_w");
        return;
      end
      if (AdaptEN) en_cnt++;
      if (AdaptEN && !prev_en && tap < TAPS) begin
        check_val("issue_sig", AdaptSigIn, mx[tap]);
        check_val("issue_wz", AdaptWzIn, mw[tap]);
        check_val("issue_err", AdaptErr, me);
        mw[tap] = mw[tap] + delta(mx[tap], me);
        tap++;
      end
      prev_en = AdaptEN;
      if (Done) begin
        seen_done = 1'b1;
        WeightClr = 1'b0;
        break;
      end
      WeightClr = 1'($urandom_range(0, 1));
      if (cyc == ov_at) begin
        SampleStrobe = 1'b1;
        SigIn        = DW'($urandom);
        movr         = 1'b1;
      end else begin
        SampleStrobe = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    WeightClr = 1'b0; SampleStrobe = 1'b0;
    check_val("done_seen", seen_done, 1);
    check_val("pass_len", cyc, f ? 2 : 2 + TAPS * (ADAPT_LAT + 1));
    check_val("en_cycles", en_cnt, f ? 0 : TAPS * ADAPT_LAT);
    check_val("taps_issued", tap, f ? 0 : TAPS);
    check_val("err_latch", AdaptErr, me);
    check_val("overrun", Overrun, movr);
  endtask

  initial begin
    Reset_n = 1'b0; SampleStrobe = 1'b0; SigIn = '0; ErrIn = '0;
    Freeze = 1'b0; WeightClr = 1'b0; CoefAddr = '0; rich = 1'b0;
    p1 = '0; p2 = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_idle_outs("reset");
    Reset_n = 1'b1;

    run_pass(DW'(20), DW'(10), 1'b0, 0, 0);
    sweep("w_after_first");
    run_pass(DW'(5), DW'(1), 1'b0, 0, 0);
    run_pass(DW'(6), DW'(2), 1'b0, 0, 0);
    run_pass(DW'(7), DW'(3), 1'b0, 0, 0);
    sweep("w_after_three");
    run_pass(11'h7FD, DW'(4), 1'b1, 0, 0);
    sweep("w_after_freeze");
    run_pass(DW'(9), DW'(5), 1'b0, 8, 0);
    sweep("w_after_overrun");
    run_pass(DW'(12), DW'(6), 1'b0, 0, 0);

    @(posedge clk); #1 WeightClr = 1'b1;
    @(posedge clk); #1 WeightClr = 1'b0;
    for (int i = 0; i < TAPS; i++) mw[i] = '0;
    movr = 1'b0;
    check_val("clr_overrun", Overrun, 0);
    sweep("w_after_clr");

    run_pass(DW'(33), DW'(7), 1'b0, 0, 6);
    run_pass(DW'(44), DW'(8), 1'b0, 0, 0);
    sweep("w_after_rst_pass");

    rich = 1'b1;
    for (int n = 0; n < 24; n++) begin
      run_pass(DW'($urandom), DW'($urandom), ($urandom_range(0, 4) == 0),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 12)) : 0, 0);
      if (n % 6 == 5) sweep("w_random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
